adc_spi_responder: RTL and testbench

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

---
 rtl/adc_spi_responder.sv | 134 +++++++++++++
 tb/tb_adc_spi_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// SPI responder that serves a held parallel sample MSB-first on chip_data_out, shifting on falling dclk.
// Frames close on chip-select rise with a one-cycle done or abort pulse; stale_out flags repeated samples.
module adc_spi_responder #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  output logic                  chip_data_out,
  output logic                  frame_done_out,
  output logic                  frame_abort_out,
  output logic                  stale_out
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state;
  logic                    clk_q;
  logic                    sel_q;
  logic [DATA_WIDTH-1:0]   holding;
  logic                    fresh;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [DATA_WIDTH-1:0]   shreg_next;
  logic [CW-1:0]           bit_cnt;
  logic [CW-1:0]           rise_cnt;
  logic                    cs_fall;
  logic                    cs_rise;
  logic                    sclk_fall;
  logic                    sclk_rise;

  // Inputs are already in the clk_in domain, so one register suffices for edge detection.
  assign cs_fall   = sel_q & ~chip_sel_in;
  assign cs_rise   = ~sel_q & chip_sel_in;
  assign sclk_fall = clk_q & ~chip_clk_in;
  assign sclk_rise = ~clk_q & chip_clk_in;

  always_comb begin
    shreg_next = shreg << 1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      clk_q           <= 1'b0;
      sel_q           <= 1'b0;
      holding         <= '0;
      fresh           <= 1'b0;
      shreg           <= '0;
      bit_cnt         <= '0;
      rise_cnt        <= '0;
      chip_data_out   <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_abort_out <= 1'b0;
      stale_out       <= 1'b1;
    end else begin
      clk_q           <= chip_clk_in;
      sel_q           <= chip_sel_in;
      frame_done_out  <= 1'b0;
      frame_abort_out <= 1'b0;

      if (sample_valid_in) begin
        holding <= sample_in;
        fresh   <= 1'b1;
      end

      // Rising dclk edges decide done vs abort; saturate so extra edges cannot wrap.
      if (state != IDLE && !chip_sel_in && sclk_rise && rise_cnt != FULL_CNT) begin
        rise_cnt <= rise_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          chip_data_out <= 1'b0;
          if (cs_fall) begin
            // The frame takes the value held before this edge; a same-cycle load waits for the next frame.
            shreg         <= holding;
            chip_data_out <= holding[DATA_WIDTH-1];
            bit_cnt       <= '0;
            rise_cnt      <= '0;
            stale_out     <= ~fresh;
            if (!sample_valid_in) begin
              fresh <= 1'b0;
            end
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            state           <= IDLE;
            chip_data_out   <= 1'b0;
            frame_done_out  <= (rise_cnt == FULL_CNT);
            frame_abort_out <= (rise_cnt != FULL_CNT);
          end else if (sclk_fall && !chip_sel_in) begin
            if (bit_cnt == LAST_BIT) begin
              state         <= DONE;
              chip_data_out <= 1'b0;
            end else begin
              shreg         <= shreg_next;
              chip_data_out <= shreg_next[DATA_WIDTH-1];
              bit_cnt       <= bit_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          chip_data_out <= 1'b0;
          if (cs_rise) begin
            state           <= IDLE;
            frame_done_out  <= (rise_cnt == FULL_CNT);
            frame_abort_out <= (rise_cnt != FULL_CNT);
          end
        end

        default: begin
          state         <= IDLE;
          chip_data_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: acts as the SPI controller and checks served frames against a scoreboard.
module tb_adc_spi_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] sample_in;
  logic        sample_valid_in;
  logic        chip_clk_in;
  logic        chip_sel_in;
  logic        chip_data_out;
  logic        frame_done_out;
  logic        frame_abort_out;
  logic        stale_out;

  adc_spi_responder #(.DATA_WIDTH(16)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .chip_clk_in     (chip_clk_in),
    .chip_sel_in     (chip_sel_in),
    .chip_data_out   (chip_data_out),
    .frame_done_out  (frame_done_out),
    .frame_abort_out (frame_abort_out),
    .stale_out       (stale_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [15:0] data;
    logic        stale;
    int          done;
    int          abort;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] hold_m;
  logic        fresh_m;

  // Pulse monitor: counts pulses and any pulse lasting more than one cycle.
  int   done_seen = 0;
  int   abort_seen = 0;
  int   long_pulses = 0;
  logic done_prev = 1'b0;
  logic abort_prev = 1'b0;
  always @(negedge clk_in) begin
    if (frame_done_out) done_seen++;
    if (frame_abort_out) abort_seen++;
    if ((frame_done_out && done_prev) || (frame_abort_out && abort_prev)) long_pulses++;
    done_prev  = frame_done_out;
    abort_prev = frame_abort_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    sample_in = v;
    sample_valid_in = 1'b1;
    tick();
    sample_valid_in = 1'b0;
    hold_m  = v;
    fresh_m = 1'b1;
  endtask

  // Controller samples data on each dclk rise; low phase 3 clk, high phase 2 clk.
  task automatic shift_bits(input int n, output logic [15:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      got = {got[14:0], chip_data_out};
      chip_clk_in = 1'b1;
      tick(); tick();
      chip_clk_in = 1'b0;
      tick(); tick(); tick();
    end
  endtask

  task automatic run_frame(input string tag, input int nrise, input bit with_load, input logic [15:0] new_val);
    exp_t        e;
    exp_t        p;
    logic [15:0] got;
    int          d0;
    int          a0;
    e.data  = hold_m >> (16 - nrise);
    e.stale = ~fresh_m;
    e.done  = (nrise == 16) ? 1 : 0;
    e.abort = (nrise == 16) ? 0 : 1;
    exp_q.push_back(e);
    fresh_m = with_load;
    if (with_load) hold_m = new_val;

    d0 = done_seen;
    a0 = abort_seen;
    chip_sel_in = 1'b0;
    if (with_load) begin
      sample_in = new_val;
      sample_valid_in = 1'b1;
    end
    tick();
    sample_valid_in = 1'b0;
    tick(); tick();
    shift_bits(nrise, got);
    chip_sel_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    p = exp_q.pop_front();
    check({tag, "_bits"}, 32'(got), 32'(p.data));
    check({tag, "_stale"}, 32'(stale_out), 32'(p.stale));
    check({tag, "_done"}, 32'(done_seen - d0), 32'(p.done));
    check({tag, "_abort"}, 32'(abort_seen - a0), 32'(p.abort));
    check({tag, "_cipo_idle"}, 32'(chip_data_out), 32'd0);
  endtask

  initial begin
    logic [15:0] got;
    int          d0;
    int          a0;
    rst_in = 1'b1;
    sample_in = '0;
    sample_valid_in = 1'b0;
    chip_clk_in = 1'b0;
    chip_sel_in = 1'b1;
    hold_m = '0;
    fresh_m = 1'b0;
    tick(); tick(); tick();
    check("rst_cipo", 32'(chip_data_out), 32'd0);
    check("rst_done", 32'(frame_done_out), 32'd0);
    check("rst_abort", 32'(frame_abort_out), 32'd0);
    check("rst_stale", 32'(stale_out), 32'd1);
    rst_in = 1'b0;
    tick(); tick();

    load(16'hA5C3);
    run_frame("f1_a5c3", 16, 1'b0, '0);
    run_frame("f2_repeat", 16, 1'b0, '0);
    run_frame("f3_abort7", 7, 1'b0, '0);
    run_frame("f4_after_abort", 16, 1'b0, '0);

    load(16'hFFFF);
    run_frame("f5_old_on_fall", 16, 1'b1, 16'h1234);
    run_frame("f6_new_1234", 16, 1'b0, '0);

    // Reset after 5 bits: silent abort, holding cleared.
    d0 = done_seen;
    a0 = abort_seen;
    chip_sel_in = 1'b0;
    tick(); tick(); tick();
    shift_bits(5, got);
    check("mid_bits", 32'(got), 32'(hold_m >> 11));
    rst_in = 1'b1;
    chip_sel_in = 1'b1;
    tick();
    check("mid_rst_cipo", 32'(chip_data_out), 32'd0);
    tick();
    rst_in = 1'b0;
    hold_m = '0;
    fresh_m = 1'b0;
    tick(); tick(); tick();
    check("mid_rst_done", 32'(done_seen - d0), 32'd0);
    check("mid_rst_abort", 32'(abort_seen - a0), 32'd0);
    check("mid_rst_stale", 32'(stale_out), 32'd1);
    run_frame("f7_zero", 16, 1'b0, '0);

    // CS low across reset release: the frame must not start.
    chip_sel_in = 1'b0;
    rst_in = 1'b1;
    tick(); tick(); tick();
    rst_in = 1'b0;
    d0 = done_seen;
    a0 = abort_seen;
    load(16'h5A5A);
    tick();
    shift_bits(16, got);
    check("held_cs_bits", 32'(got), 32'd0);
    chip_sel_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("held_cs_done", 32'(done_seen - d0), 32'd0);
    check("held_cs_abort", 32'(abort_seen - a0), 32'd0);
    check("held_cs_stale", 32'(stale_out), 32'd1);
    run_frame("f8_5a5a", 16, 1'b0, '0);

    check("pulse_width", 32'(long_pulses), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
